// File: rtl/mips_exec_pkg.sv
// Shared encodings for the MIPS decode/execute slice: opcodes, funct codes,
// ALU operation selects and the registered control bundle.
package mips_exec_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALUCTL_AND = 4'b0000;
  localparam logic [3:0] ALUCTL_OR  = 4'b0001;
  localparam logic [3:0] ALUCTL_ADD = 4'b0010;
  localparam logic [3:0] ALUCTL_SUB = 4'b0110;
  localparam logic [3:0] ALUCTL_SLT = 4'b0111;
  localparam logic [3:0] ALUCTL_NOR = 4'b1100;
  localparam logic [3:0] ALUCTL_XOR = 4'b1101;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ADD    = 2'b11;

  // Control bits carried into the EX/MEM register.
  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
    logic memtoreg;
    logic branch_eq;
    logic branch_ne;
    logic jump;
  } ex_ctl_t;

  function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mips_alu_core.sv
// Combinational ALU: operation select, zero flag and, when EXEC_OVERFLOW_EN
// is defined, signed overflow for add/sub.
module mips_alu_core
  import mips_exec_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [3:0]   aluctl_i,
  output logic [W-1:0] result_o,
  output logic         zero_o
`ifdef EXEC_OVERFLOW_EN
  ,
  output logic         ovf_o
`endif
);

  logic [W-1:0] sum;
  logic [W-1:0] diff;

  assign sum  = a_i + b_i;
  assign diff = a_i - b_i;

  always_comb begin
    result_o = '0;
    case (aluctl_i)
      ALUCTL_AND: result_o = a_i & b_i;
      ALUCTL_OR:  result_o = a_i | b_i;
      ALUCTL_ADD: result_o = sum;
      ALUCTL_SUB: result_o = diff;
      ALUCTL_SLT: result_o = {{(W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALUCTL_NOR: result_o = ~(a_i | b_i);
      ALUCTL_XOR: result_o = a_i ^ b_i;
      default:    result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

`ifdef EXEC_OVERFLOW_EN
  // Overflow when operand signs agree (add) or differ (sub) and the result sign flips.
  always_comb begin
    ovf_o = 1'b0;
    case (aluctl_i)
      ALUCTL_ADD: ovf_o = (a_i[W-1] == b_i[W-1]) && (sum[W-1] != a_i[W-1]);
      ALUCTL_SUB: ovf_o = (a_i[W-1] != b_i[W-1]) && (diff[W-1] != a_i[W-1]);
      default:    ovf_o = 1'b0;
    endcase
  end
`endif

endmodule

// File: rtl/mips_exec_unit.sv
// MIPS decode-and-execute slice with a 1-cycle EX/MEM register stage.
// Optional signed overflow reporting on ovf_q is enabled by EXEC_OVERFLOW_EN.
module mips_exec_unit
  import mips_exec_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  instr,
  input  logic [W-1:0] rs_data,
  input  logic [W-1:0] rt_data,
  input  logic         stall,
  input  logic         flush,
  output logic         regdst,
  output logic         alusrc,
  output logic         memread,
  output logic         memwrite,
  output logic         memtoreg,
  output logic         regwrite,
  output logic         branch_eq,
  output logic         branch_ne,
  output logic         jump,
  output logic [1:0]   aluop,
  output logic [3:0]   aluctl,
  output logic [W-1:0] result_q,
  output logic         zero_q,
  output logic [4:0]   wrreg_q,
  output logic         regwrite_q,
  output logic         memread_q,
  output logic         memwrite_q,
  output logic         memtoreg_q,
  output logic         branch_eq_q,
  output logic         branch_ne_q,
  output logic         jump_q,
  output logic         ovf_q
);

  logic [5:0]   opcode;
  logic [5:0]   funct;
  logic [4:0]   rt_idx;
  logic [4:0]   rd_idx;
  logic [W-1:0] imm_sx;
  logic [W-1:0] alu_b;
  logic [W-1:0] alu_result;
  logic         alu_zero;
  logic [4:0]   wrreg_d;
  ex_ctl_t      ctl_d;
  ex_ctl_t      ctl_q;
  logic         unused_instr;

  assign opcode = instr[31:26];
  assign rt_idx = instr[20:16];
  assign rd_idx = instr[15:11];
  assign funct  = instr[5:0];
  assign imm_sx = sign_ext16(instr[15:0]);
  // rs index and shamt are resolved outside this slice.
  assign unused_instr = ^{instr[25:21], instr[10:6]};

  always_comb begin
    regdst    = 1'b0;
    alusrc    = 1'b0;
    memread   = 1'b0;
    memwrite  = 1'b0;
    memtoreg  = 1'b0;
    regwrite  = 1'b0;
    branch_eq = 1'b0;
    branch_ne = 1'b0;
    jump      = 1'b0;
    aluop     = ALUOP_MEM;
    case (opcode)
      OP_RTYPE: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        aluop    = ALUOP_RTYPE;
      end
      OP_LW: begin
        memread  = 1'b1;
        memtoreg = 1'b1;
        regwrite = 1'b1;
        alusrc   = 1'b1;
      end
      OP_SW: begin
        memwrite = 1'b1;
        alusrc   = 1'b1;
      end
      OP_ADDI: begin
        regwrite = 1'b1;
        alusrc   = 1'b1;
      end
      OP_BEQ: begin
        branch_eq = 1'b1;
        aluop     = ALUOP_BRANCH;
      end
      OP_BNE: begin
        branch_ne = 1'b1;
        aluop     = ALUOP_BRANCH;
      end
      OP_J:    jump = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    aluctl = ALUCTL_ADD;
    case (aluop)
      ALUOP_MEM:    aluctl = ALUCTL_ADD;
      ALUOP_BRANCH: aluctl = ALUCTL_SUB;
      ALUOP_ADD:    aluctl = ALUCTL_ADD;
      ALUOP_RTYPE: begin
        case (funct)
          FN_ADD:  aluctl = ALUCTL_ADD;
          FN_SUB:  aluctl = ALUCTL_SUB;
          FN_AND:  aluctl = ALUCTL_AND;
          FN_OR:   aluctl = ALUCTL_OR;
          FN_XOR:  aluctl = ALUCTL_XOR;
          FN_NOR:  aluctl = ALUCTL_NOR;
          FN_SLT:  aluctl = ALUCTL_SLT;
          default: aluctl = ALUCTL_AND;
        endcase
      end
      default:      aluctl = ALUCTL_ADD;
    endcase
  end

  assign alu_b   = alusrc ? imm_sx : rt_data;
  assign wrreg_d = regdst ? rd_idx : rt_idx;

  always_comb begin
    ctl_d           = '0;
    ctl_d.regwrite  = regwrite;
    ctl_d.memread   = memread;
    ctl_d.memwrite  = memwrite;
    ctl_d.memtoreg  = memtoreg;
    ctl_d.branch_eq = branch_eq;
    ctl_d.branch_ne = branch_ne;
    ctl_d.jump      = jump;
  end

`ifdef EXEC_OVERFLOW_EN
  logic alu_ovf;
`endif

  mips_alu_core #(
    .W(W)
  ) u_alu (
    .a_i      (rs_data),
    .b_i      (alu_b),
    .aluctl_i (aluctl),
    .result_o (alu_result),
    .zero_o   (alu_zero)
`ifdef EXEC_OVERFLOW_EN
    ,
    .ovf_o    (alu_ovf)
`endif
  );

  // A stall turns the slot into a bubble but still lets the datapath capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      zero_q   <= 1'b0;
      wrreg_q  <= '0;
      ctl_q    <= '0;
    end else if (flush) begin
      result_q <= '0;
      zero_q   <= 1'b0;
      wrreg_q  <= '0;
      ctl_q    <= '0;
    end else begin
      result_q <= alu_result;
      zero_q   <= alu_zero;
      wrreg_q  <= wrreg_d;
      ctl_q    <= stall ? '0 : ctl_d;
    end
  end

`ifdef EXEC_OVERFLOW_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (flush) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= alu_ovf;
    end
  end
`else
  assign ovf_q = 1'b0;
`endif

  assign regwrite_q  = ctl_q.regwrite;
  assign memread_q   = ctl_q.memread;
  assign memwrite_q  = ctl_q.memwrite;
  assign memtoreg_q  = ctl_q.memtoreg;
  assign branch_eq_q = ctl_q.branch_eq;
  assign branch_ne_q = ctl_q.branch_ne;
  assign jump_q      = ctl_q.jump;

endmodule

// File: tb/tb_mips_exec_unit.sv
// Scoreboard bench for mips_exec_unit: directed cases plus randomized
// instructions checked against an instruction-level reference model.
module tb_mips_exec_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        stall;
  logic        flush;
  logic        regdst, alusrc, memread, memwrite, memtoreg, regwrite;
  logic        branch_eq, branch_ne, jump;
  logic [1:0]  aluop;
  logic [3:0]  aluctl;
  logic [31:0] result_q;
  logic        zero_q;
  logic [4:0]  wrreg_q;
  logic        regwrite_q, memread_q, memwrite_q, memtoreg_q;
  logic        branch_eq_q, branch_ne_q, jump_q, ovf_q;

  mips_exec_unit #(.W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .stall       (stall),
    .flush       (flush),
    .regdst      (regdst),
    .alusrc      (alusrc),
    .memread     (memread),
    .memwrite    (memwrite),
    .memtoreg    (memtoreg),
    .regwrite    (regwrite),
    .branch_eq   (branch_eq),
    .branch_ne   (branch_ne),
    .jump        (jump),
    .aluop       (aluop),
    .aluctl      (aluctl),
    .result_q    (result_q),
    .zero_q      (zero_q),
    .wrreg_q     (wrreg_q),
    .regwrite_q  (regwrite_q),
    .memread_q   (memread_q),
    .memwrite_q  (memwrite_q),
    .memtoreg_q  (memtoreg_q),
    .branch_eq_q (branch_eq_q),
    .branch_ne_q (branch_ne_q),
    .jump_q      (jump_q),
    .ovf_q       (ovf_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected registered response; ctl = {regwrite,memread,memwrite,memtoreg,beq,bne,j}.
  typedef struct {
    logic [31:0] result;
    logic        zero;
    logic [4:0]  wrreg;
    logic [6:0]  ctl;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Instruction-level semantics: what each MIPS instruction should do.
  task automatic model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] rtv,
                       output logic [8:0] dec, output logic [1:0] aop,
                       output logic [3:0] actl, output exp_t e);
    string       op;
    logic [31:0] b;
    logic [31:0] sx;
    logic        rdsel;
    longint      wide;
    sx    = {{16{ins[15]}}, ins[15:0]};
    b     = rtv;
    op    = "add";
    dec   = '0;  // {regdst,alusrc,memread,memwrite,memtoreg,regwrite,beq,bne,j}
    aop   = 2'd0;
    case (ins[31:26])
      6'h00: begin
        dec = 9'b1_0000_1000; aop = 2'd2;
        case (ins[5:0])
          6'h20: op = "add";
          6'h22: op = "sub";
          6'h24: op = "and";
          6'h25: op = "or";
          6'h26: op = "xor";
          6'h27: op = "nor";
          6'h2a: op = "slt";
          default: op = "and";
        endcase
      end
      6'h23: begin dec = 9'b0_1101_1000; b = sx; end
      6'h2b: begin dec = 9'b0_1010_0000; b = sx; end
      6'h08: begin dec = 9'b0_1000_1000; b = sx; end
      6'h04: begin dec = 9'b0_0000_0100; aop = 2'd1; op = "sub"; end
      6'h05: begin dec = 9'b0_0000_0010; aop = 2'd1; op = "sub"; end
      6'h02: dec = 9'b0_0000_0001;
      default: ;
    endcase
    case (op)
      "add": begin actl = 4'b0010; e.result = a + b; end
      "sub": begin actl = 4'b0110; e.result = a - b; end
      "and": begin actl = 4'b0000; e.result = a & b; end
      "or":  begin actl = 4'b0001; e.result = a | b; end
      "xor": begin actl = 4'b1101; e.result = a ^ b; end
      "nor": begin actl = 4'b1100; e.result = ~(a | b); end
      default: begin actl = 4'b0111; e.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
    endcase
    e.zero  = (e.result == 32'd0);
    rdsel   = dec[8];
    e.wrreg = rdsel ? ins[15:11] : ins[20:16];
    e.ctl   = {dec[3], dec[6], dec[5], dec[4], dec[2], dec[1], dec[0]};
    e.ovf   = 1'b0;
`ifdef EXEC_OVERFLOW_EN
    if (op == "add") wide = longint'($signed(a)) + longint'($signed(b));
    else if (op == "sub") wide = longint'($signed(a)) - longint'($signed(b));
    else wide = 0;
    e.ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
`else
    wide = 0;
`endif
  endtask

  // Drive one instruction at the falling edge, check decode, queue the capture.
  task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                       input logic st, input logic fl);
    logic [8:0] dec;
    logic [1:0] aop;
    logic [3:0] actl;
    exp_t       e;
    @(negedge clk);
    instr = ins; rs_data = a; rt_data = b; stall = st; flush = fl;
    model(ins, a, b, dec, aop, actl, e);
    if (fl) begin
      e.result = '0; e.zero = 1'b0; e.wrreg = '0; e.ctl = '0; e.ovf = 1'b0;
    end else if (st) begin
      e.ctl = '0;
    end
    exp_q.push_back(e);
    #1;
    chk("decode", {regdst, alusrc, memread, memwrite, memtoreg, regwrite, branch_eq,
                   branch_ne, jump}, dec);
    chk("aluop", aluop, aop);
    chk("aluctl", aluctl, actl);
  endtask

  // Monitor: every rising edge with an outstanding issue presents one response.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("result_q", result_q, e.result);
      chk("zero_q", zero_q, e.zero);
      chk("wrreg_q", wrreg_q, e.wrreg);
      chk("ctl_q", {regwrite_q, memread_q, memwrite_q, memtoreg_q, branch_eq_q, branch_ne_q,
                    jump_q}, e.ctl);
      chk("ovf_q", ovf_q, e.ovf);
    end
  end

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt,
                                        input logic [15:0] imm);
    return {op, 5'd1, rt, imm};
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] sel [5];
    sel[0] = 32'h0; sel[1] = 32'h1; sel[2] = 32'h7FFF_FFFF;
    sel[3] = 32'h8000_0000; sel[4] = 32'hFFFF_FFFF;
    if ($urandom_range(0, 2) == 0) return sel[$urandom_range(0, 4)];
    return $urandom();
  endfunction

  initial begin
    logic [5:0]  ops [8];
    logic [5:0]  fns [8];
    logic [31:0] ins, a, b;
    ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2b; ops[3] = 6'h08;
    ops[4] = 6'h04; ops[5] = 6'h05; ops[6] = 6'h02; ops[7] = 6'h3f;
    fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h25;
    fns[4] = 6'h26; fns[5] = 6'h27; fns[6] = 6'h2a; fns[7] = 6'h00;

    rst_n = 1'b0; instr = '0; rs_data = '0; rt_data = '0; stall = 1'b0; flush = 1'b0;
    #12;
    chk("reset_state", {result_q, zero_q, wrreg_q, regwrite_q, memread_q, memwrite_q,
                        memtoreg_q, branch_eq_q, branch_ne_q, jump_q, ovf_q}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases from the feature list and boundary conditions.
    issue(rtype(5'd1, 5'd2, 5'd5, 6'h20), 32'd3, 32'd4, 1'b0, 1'b0);
    issue(itype(6'h04, 5'd2, 16'h0010), 32'h1234, 32'h1234, 1'b0, 1'b0);
    issue(itype(6'h05, 5'd2, 16'h0010), 32'd1, 32'd2, 1'b0, 1'b0);
    issue(itype(6'h23, 5'd9, 16'hFFFC), 32'h100, 32'h0, 1'b0, 1'b0);
    issue(rtype(5'd1, 5'd2, 5'd3, 6'h2a), 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    issue(rtype(5'd1, 5'd2, 5'd3, 6'h2a), 32'h8000_0000, 32'd1, 1'b0, 1'b0);
    issue(rtype(5'd1, 5'd2, 5'd3, 6'h27), 32'd0, 32'd0, 1'b0, 1'b0);
    issue(rtype(5'd1, 5'd2, 5'd3, 6'h20), 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
    issue(rtype(5'd1, 5'd2, 5'd3, 6'h20), 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    issue(rtype(5'd1, 5'd2, 5'd3, 6'h22), 32'h8000_0000, 32'd1, 1'b0, 1'b0);
    issue(itype(6'h2b, 5'd4, 16'h0008), 32'h200, 32'h55, 1'b1, 1'b0);
    issue(itype(6'h2b, 5'd4, 16'h0008), 32'h200, 32'h55, 1'b1, 1'b1);
    issue(itype(6'h02, 5'd0, 16'h0040), 32'd6, 32'd7, 1'b0, 1'b0);

    // Asynchronous reset mid-run after result_q has captured 5.
    issue(itype(6'h08, 5'd7, 16'h0003), 32'd2, 32'd0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {result_q, zero_q, wrreg_q, regwrite_q, memread_q, memwrite_q,
                        memtoreg_q, branch_eq_q, branch_ne_q, jump_q, ovf_q}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 7) ins = {$urandom_range(0, 63), 26'd0} | $urandom();
      else ins = {ops[$urandom_range(0, 7)], 26'd0} | ($urandom() & 32'h03FF_FFC0);
      if (ins[31:26] == 6'h00) ins[5:0] = fns[$urandom_range(0, 7)];
      a = pick_operand();
      b = ($urandom_range(0, 5) == 0) ? a : pick_operand();
      issue(ins, a, b, $urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0);
    end

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
